// File: rtl/cc_line_serializer_pkg.sv
// Shared types and entry-field helpers for the cache-line serializer.
// Entries are packed as {mode, byte_offset, line}.
package cc_pkg;

   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_INCR = 1'b1
   } mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   // Helpers take the entry zero-extended to this width so that one
   // definition serves every LINE_W/DATA_W combination.
   localparam int MAX_ENTRY_W = 2048;

   function automatic mode_e entry_mode(input logic [MAX_ENTRY_W-1:0] entry,
                                        input int line_w,
                                        input int bofs_w);
      return mode_e'(1'(entry >> (line_w + bofs_w)));
   endfunction

   function automatic logic [31:0] entry_start_beat(input logic [MAX_ENTRY_W-1:0] entry,
                                                    input int line_w,
                                                    input int bofs_w,
                                                    input int beat_w);
      logic [31:0] field;
      field = 32'(entry >> (line_w + bofs_w - beat_w));
      return field & ((32'd1 << beat_w) - 32'd1);
   endfunction

endpackage

// File: rtl/cc_line_serializer_if.sv
// FIFO-side and beat-stream signals of the line serializer, bundled with
// a master view for the serializer and a slave view for its environment.
interface cc_line_serializer_if #(
   parameter int LINE_W = 512,
   parameter int DATA_W = 64
);
   import cc_pkg::*;

   localparam int BOFS_W  = $clog2(LINE_W / 8);
   localparam int ENTRY_W = 1 + BOFS_W + LINE_W;

   logic               fifo_empty_i;
   logic [ENTRY_W-1:0] fifo_rdata_i;
   logic               fifo_rden_o;
   logic [DATA_W-1:0]  rdata_o;
   logic               rlast_o;
   logic               rvalid_o;
   logic               rready_i;
   logic               busy_o;

   modport master (
      input  fifo_empty_i, fifo_rdata_i, rready_i,
      output fifo_rden_o, rdata_o, rlast_o, rvalid_o, busy_o
   );

   modport slave (
      output fifo_empty_i, fifo_rdata_i, rready_i,
      input  fifo_rden_o, rdata_o, rlast_o, rvalid_o, busy_o
   );

endinterface

// File: rtl/cc_line_serializer_beat_mux.sv
// Purely combinational selection of one DATA_W beat out of a cache line.
module cc_beat_mux #(
   parameter int LINE_W = 512,
   parameter int DATA_W = 64
) (
   input  logic [LINE_W-1:0]                  line,
   input  logic [$clog2(LINE_W/DATA_W)-1:0]   idx,
   output logic [DATA_W-1:0]                  beat
);
   import cc_pkg::*;

   localparam int BEATS = LINE_W / DATA_W;

   logic [DATA_W-1:0] beats [BEATS];

   for (genvar k = 0; k < BEATS; k++) begin : g_split
      assign beats[k] = line[k*DATA_W +: DATA_W];
   end

   assign beat = beats[idx];

endmodule

// File: rtl/cc_line_serializer.sv
// Pops cache lines from a show-ahead FIFO and streams them as DATA_W beats
// in WRAP or INCR order, chaining back-to-back lines without a bubble.
module cc_line_serializer #(
   parameter int LINE_W = 512,
   parameter int DATA_W = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   cc_line_serializer_if.master bus
);
   import cc_pkg::*;

   localparam int BEATS   = LINE_W / DATA_W;
   localparam int BEAT_W  = $clog2(BEATS);
   localparam int BOFS_W  = $clog2(LINE_W / 8);
   localparam int ENTRY_W = 1 + BOFS_W + LINE_W;
   localparam logic [BEAT_W-1:0] LAST_IDX = BEAT_W'(BEATS - 1);

   state_e              state_q, state_d;
   mode_e               mode_q, mode_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [BEAT_W-1:0]   start_q, start_d;
   logic [LINE_W-1:0]   line_q, line_d;

   logic [ENTRY_W-1:0]  entry;
   logic                last_beat;
   logic                handshake;
   logic                pop;

   assign entry = bus.fifo_rdata_i;

   // A WRAP line ends on the index just before its start; INCR always ends on the top beat.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      beat_d    = beat_q;
      start_d   = start_q;
      line_d    = line_q;
      pop       = 1'b0;
      last_beat = (mode_q == MODE_INCR) ? (beat_q == LAST_IDX)
                                        : (beat_q == start_q - BEAT_W'(1));
      handshake = (state_q == ST_SEND) && bus.rready_i;

      case (state_q)
         ST_IDLE: pop = !bus.fifo_empty_i;
         ST_SEND: begin
            if (handshake) begin
               if (!last_beat) begin
                  beat_d = beat_q + BEAT_W'(1);
               end else if (!bus.fifo_empty_i) begin
                  pop = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (pop) begin
         state_d = ST_SEND;
         line_d  = entry[LINE_W-1:0];
         mode_d  = entry_mode(MAX_ENTRY_W'(entry), LINE_W, BOFS_W);
         start_d = BEAT_W'(entry_start_beat(MAX_ENTRY_W'(entry), LINE_W, BOFS_W, BEAT_W));
         beat_d  = start_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_WRAP;
         beat_q  <= '0;
         start_q <= '0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         beat_q  <= beat_d;
         start_q <= start_d;
         line_q  <= line_d;
      end
   end

   cc_beat_mux #(
      .LINE_W (LINE_W),
      .DATA_W (DATA_W)
   ) u_beat_mux (
      .line (line_q),
      .idx  (beat_q),
      .beat (bus.rdata_o)
   );

   assign bus.fifo_rden_o = pop && !rst;
   assign bus.rvalid_o    = (state_q == ST_SEND);
   assign bus.busy_o      = (state_q == ST_SEND);
   assign bus.rlast_o     = (state_q == ST_SEND) && last_beat;

endmodule

// File: tb/tb_cc_line_serializer.sv
// Randomized bench for cc_line_serializer: a queue-based FIFO and beat-order
// model derived from the WRAP/INCR rules, plus a directed 4-beat variant.
module tb_cc_line_serializer;

   localparam int LINE_W  = 512;
   localparam int DATA_W  = 64;
   localparam int ENTRY_W = 1 + 6 + LINE_W;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              last;
   } beat_t;

   logic clk;
   logic rst;

   cc_line_serializer_if #(.LINE_W(LINE_W), .DATA_W(DATA_W)) bus0 ();
   cc_line_serializer_if #(.LINE_W(512),    .DATA_W(128))    bus1 ();

   cc_line_serializer #(.LINE_W(LINE_W), .DATA_W(DATA_W)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0.master)
   );

   cc_line_serializer #(.LINE_W(512), .DATA_W(128)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned checks;
   int unsigned errors;
   int unsigned hs_count;
   bit          stall_en;
   bit          rst_at_edge;

   logic [ENTRY_W-1:0] fifo_q [$];
   beat_t              exp_q  [$];

   task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [ENTRY_W-1:0] make_entry(input logic mode, input logic [5:0] bofs,
                                                     input logic [LINE_W-1:0] line);
      return {mode, bofs, line};
   endfunction

   function automatic logic [LINE_W-1:0] random_line();
      logic [LINE_W-1:0] l;
      for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom();
      return l;
   endfunction

   // Expected beat sequence of one popped entry, straight from the ordering rules.
   task automatic append_beats(input logic [ENTRY_W-1:0] e);
      logic              mode;
      logic [LINE_W-1:0] line;
      int                start;
      beat_t             b;
      mode  = e[ENTRY_W-1];
      line  = e[LINE_W-1:0];
      start = int'(e[LINE_W +: 6]) / 8;
      if (!mode) begin
         for (int n = 0; n < 8; n++) begin
            int k;
            k      = (start + n) % 8;
            b.data = line[k*DATA_W +: DATA_W];
            b.last = (n == 7);
            exp_q.push_back(b);
         end
      end else begin
         for (int k = start; k < 8; k++) begin
            b.data = line[k*DATA_W +: DATA_W];
            b.last = (k == 7);
            exp_q.push_back(b);
         end
      end
   endtask

   task automatic drive_inputs();
      bus0.fifo_empty_i = (fifo_q.size() == 0);
      bus0.fifo_rdata_i = (fifo_q.size() != 0) ? fifo_q[0] : '0;
   endtask

   task automatic push_line(input logic mode, input logic [5:0] bofs);
      fifo_q.push_back(make_entry(mode, bofs, random_line()));
      drive_inputs();
   endtask

   task automatic apply_stimulus();
      bit exp_valid, exp_rden, pop_now, hs_now;
      @(negedge clk);
      exp_valid = (exp_q.size() != 0);
      exp_rden  = !rst && (fifo_q.size() != 0) &&
                  (!exp_valid || (bus0.rready_i && exp_q[0].last));
      check_output("rvalid", bus0.rvalid_o, exp_valid);
      check_output("busy", bus0.busy_o, exp_valid);
      check_output("fifo_rden", bus0.fifo_rden_o, exp_rden);
      if (exp_valid) begin
         check_output("rdata", bus0.rdata_o, exp_q[0].data);
         check_output("rlast", bus0.rlast_o, exp_q[0].last);
      end
      if (rst_at_edge) begin
         check_output("rst_rdata", bus0.rdata_o, 0);
         check_output("rst_rlast", bus0.rlast_o, 0);
      end
      pop_now = exp_rden;
      hs_now  = exp_valid && bus0.rready_i;
      @(posedge clk);
      #1;
      rst_at_edge = rst;
      if (rst) begin
         exp_q.delete();
      end else begin
         if (hs_now) begin
            void'(exp_q.pop_front());
            hs_count++;
         end
         if (pop_now) append_beats(fifo_q.pop_front());
      end
      bus0.rready_i = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      drive_inputs();
   endtask

   task automatic drain(input int max_cycles);
      bit done;
      done = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         if (fifo_q.size() == 0 && exp_q.size() == 0) begin
            done = 1'b1;
            break;
         end
         apply_stimulus();
      end
      if (fifo_q.size() == 0 && exp_q.size() == 0) done = 1'b1;
      check_output("drain_done", done, 1);
   endtask

   initial begin
      logic [LINE_W-1:0] line1;
      int                base;
      checks      = 0;
      errors      = 0;
      hs_count    = 0;
      stall_en    = 1'b0;
      rst         = 1'b1;
      bus0.rready_i     = 1'b1;
      bus0.fifo_empty_i = 1'b1;
      bus0.fifo_rdata_i = '0;
      bus1.rready_i     = 1'b1;
      bus1.fifo_empty_i = 1'b1;
      bus1.fifo_rdata_i = '0;

      @(posedge clk);
      #1;
      rst_at_edge = 1'b1;
      apply_stimulus();
      apply_stimulus();
      rst = 1'b0;
      apply_stimulus();

      $display("[TB] WRAP offset 16");
      push_line(1'b0, 6'd16);
      drain(40);
      apply_stimulus();

      $display("[TB] INCR start 5 and single-beat start 7");
      push_line(1'b1, 6'd45);
      drain(40);
      apply_stimulus();
      push_line(1'b1, 6'd63);
      drain(40);
      apply_stimulus();

      $display("[TB] two queued lines back to back");
      push_line(1'b0, 6'd24);
      push_line(1'b0, 6'd0);
      drain(60);
      apply_stimulus();

      $display("[TB] random lines with rready stalls");
      stall_en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         push_line(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
         repeat ($urandom_range(0, 10)) apply_stimulus();
      end
      drain(800);
      stall_en = 1'b0;
      apply_stimulus();

      $display("[TB] reset in the middle of a line");
      push_line(1'b0, 6'd8);
      push_line(1'b0, 6'd56);
      base = hs_count;
      for (int i = 0; i < 20 && hs_count < base + 3; i++) apply_stimulus();
      check_output("hs_before_rst", hs_count - base, 3);
      rst = 1'b1;
      apply_stimulus();
      apply_stimulus();
      rst = 1'b0;
      drain(40);
      apply_stimulus();

      $display("[TB] 128-bit beats, WRAP offset 48");
      line1 = random_line();
      bus1.fifo_rdata_i = {1'b0, 6'd48, line1};
      bus1.fifo_empty_i = 1'b0;
      @(negedge clk);
      check_output("w_rden", bus1.fifo_rden_o, 1);
      check_output("w_idle_valid", bus1.rvalid_o, 0);
      @(posedge clk);
      #1;
      bus1.fifo_empty_i = 1'b1;
      for (int n = 0; n < 4; n++) begin
         int k;
         k = (3 + n) % 4;
         @(negedge clk);
         check_output("w_rvalid", bus1.rvalid_o, 1);
         check_output("w_rdata", bus1.rdata_o, line1[k*128 +: 128]);
         check_output("w_rlast", bus1.rlast_o, n == 3);
         check_output("w_no_pop", bus1.fifo_rden_o, 0);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check_output("w_done_valid", bus1.rvalid_o, 0);
      check_output("w_done_busy", bus1.busy_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cc_line_serializer.md
CC_LINE_SERIALIZER -- requirements
Module: cc_line_serializer

Interface
REQ-001 SHALL have parameter LINE_W, default 512: cache-line width in bits.
REQ-002 SHALL have parameter DATA_W, default 64: beat width in bits; LINE_W/DATA_W is a power of two, at least 2.
REQ-003 SHALL derive localparams BEATS=LINE_W/DATA_W, BEAT_W=$clog2(BEATS), BOFS_W=$clog2(LINE_W/8), ENTRY_W=1+BOFS_W+LINE_W.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port fifo_empty_i, input, 1: line FIFO empty (show-ahead FIFO; head valid whenever not empty).
REQ-007 SHALL have port fifo_rdata_i, input, ENTRY_W: {mode, byte_offset[BOFS_W-1:0], line[LINE_W-1:0]}; mode 0=WRAP, 1=INCR.
REQ-008 SHALL have port fifo_rden_o, output, 1: pop FIFO head this cycle.
REQ-009 SHALL have port rdata_o, output, DATA_W: beat data.
REQ-010 SHALL have port rlast_o, output, 1: final beat of the line.
REQ-011 SHALL have port rvalid_o, output, 1: beat valid.
REQ-012 SHALL have port rready_i, input, 1: downstream accept.
REQ-013 SHALL have port busy_o, output, 1: a line is loaded and not fully sent.

Function
REQ-014 Start beat SHALL be byte_offset[BOFS_W-1 -: BEAT_W]; lower byte-offset bits are ignored.
REQ-015 Beat k of line SHALL be line[k*DATA_W +: DATA_W].
REQ-016 WRAP: SHALL emit BEATS beats, indices (start+n) mod BEATS, n=0..BEATS-1; rlast on n=BEATS-1.
REQ-017 INCR: SHALL emit BEATS-start beats, indices start..BEATS-1; rlast on index BEATS-1; start=BEATS-1 gives a single beat with rlast=1.
REQ-018 FSM SHALL have two states: IDLE (no line held) and SEND (line held, rvalid_o=1).
REQ-019 IDLE->SEND: fifo_rden_o=1 when fifo_empty_i=0; line, mode and start captured on that edge; rvalid_o=1 the next cycle (1-cycle latency).
REQ-020 SEND, handshake (rvalid_o&&rready_i) on a non-last beat: beat counter +1 next cycle.
REQ-021 SEND, handshake on the last beat with fifo_empty_i=0: SHALL pop combinationally in the same cycle, load the next line, and stay in SEND with no bubble cycle.
REQ-022 SEND, handshake on the last beat with fifo_empty_i=1: SHALL go to IDLE, rvalid_o=0 next cycle.
REQ-023 fifo_rden_o SHALL equal !fifo_empty_i && (IDLE || last-beat handshake); it is never asserted when the FIFO is empty.
REQ-024 While rvalid_o=1 and rready_i=0, rdata_o, rlast_o and rvalid_o SHALL hold stable.
REQ-025 Once asserted, rvalid_o SHALL NOT deassert until the handshake completes.
REQ-026 rdata_o, rlast_o and rvalid_o SHALL be driven from registered state only; no combinational path from rready_i to those outputs.
REQ-027 Beat index arithmetic SHALL be BEAT_W bits with natural modulo-BEATS wrap.
REQ-028 busy_o SHALL equal state==SEND.

Reset
REQ-029 While rst=1 at a clock edge: state=IDLE, beat counter=0, line register=0, rvalid_o=0, rlast_o=0, rdata_o=0, busy_o=0.
REQ-030 fifo_rden_o SHALL be 0 during any cycle with rst=1.
REQ-031 Reset mid-line SHALL discard the remaining beats; no beat is emitted until a new pop after reset deasserts.

Structure
REQ-032 The mode encoding (WRAP=0, INCR=1), the entry-field slicing helpers and the FSM state enum SHALL live in package cc_pkg.
REQ-033 Beat-index selection SHALL be a sub-module cc_beat_mux (parameters LINE_W, DATA_W; inputs line, idx; output beat), purely combinational.
REQ-034 No other sub-modules SHALL be used; the FIFO is external.

Verification
REQ-035 WRAP, byte_offset=16 (start=2), rready=1: beat order 2,3,4,5,6,7,0,1; rlast only on beat 1; rvalid one cycle after the pop.
REQ-036 INCR, start=5: three beats 5,6,7; rlast on 7; then IDLE when the FIFO is empty.
REQ-037 Two lines queued, rready=1: 16 consecutive valid beats; second pop on the cycle of the first rlast handshake; no bubble.
REQ-038 Random rready stalls: rdata_o/rlast_o stable through stalls; exactly 8 handshakes per WRAP line; no pop while the FIFO is empty.
REQ-039 rst=1 asserted after the 3rd beat of a WRAP line: outputs zero the next cycle; after release, the next line starts from its own start beat.
REQ-040 Parameter sweep DATA_W=128, LINE_W=512 (BEATS=4), WRAP, byte_offset=48: beat order 3,0,1,2.
